// File: rtl/game_flow_ctl.sv
// game_flow_ctl: IDLE -> WAIT -> GAME -> SCORE sequencer for the two-player duck game.
// Owns the round timer, the local score, the opponent score capture and the winner code.
// Optional build macro GAME_PAUSE_EN adds a pause input that freezes the round while held.
module game_flow_ctl #(
  parameter int CLK_HZ         = 75000000,
  parameter int ROUND_S        = 30,
  parameter int WAIT_TIMEOUT_S = 60,
  parameter int SCORE_W        = 8,
  parameter int TIME_W         = 7
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               play_clicked,
  input  logic               remote_start,
  input  logic               stop_req,
  input  logic               duck_hit,
  input  logic [SCORE_W-1:0] op_score,
  input  logic               op_score_valid,
`ifdef GAME_PAUSE_EN
  input  logic               pause,
`endif
  output logic [1:0]         state,
  output logic               start_req,
  output logic               new_target,
  output logic [SCORE_W-1:0] my_score,
  output logic [TIME_W-1:0]  time_left,
  output logic [1:0]         winner
);

  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int TMO_W   = (WAIT_TIMEOUT_S > 1) ? $clog2(WAIT_TIMEOUT_S + 1) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(WAIT_TIMEOUT_S - 1);
  localparam logic [TIME_W-1:0]  ROUND_T    = TIME_W'(ROUND_S);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WAIT  = 2'b01,
    S_GAME  = 2'b10,
    S_SCORE = 2'b11
  } state_t;

  state_t              cur_state;
  state_t              next_state;
  logic [PRESC_W-1:0]  presc;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                remote_seen;
  logic                op_captured;
  logic                paused;
  logic                tick;
  logic                game_run;
  logic                hit_ok;
  logic                state_change;
  logic                enter_game;
  logic                score_to_idle;

`ifdef GAME_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign tick          = (presc == PRESC_LAST);
  assign game_run      = (cur_state == S_GAME) && !paused;
  assign hit_ok        = duck_hit && game_run;
  assign state_change  = (next_state != cur_state);
  assign enter_game    = (next_state == S_GAME) && (cur_state != S_GAME);
  assign score_to_idle = (cur_state == S_SCORE) && (next_state == S_IDLE);
  assign state         = cur_state;

  // State register
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) cur_state <= S_IDLE;
    else     cur_state <= next_state;
  end

  // Next-state decode; in WAIT a remote start beats stop, which beats the timeout
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_IDLE:  if (play_clicked) next_state = S_WAIT;
      S_WAIT: begin
        if (remote_seen || remote_start)       next_state = S_GAME;
        else if (stop_req)                     next_state = S_IDLE;
        else if (tick && (tmo_cnt == TMO_LAST)) next_state = S_IDLE;
      end
      S_GAME: begin
        if (stop_req)                                             next_state = S_SCORE;
        else if (game_run && tick && (time_left == TIME_W'(1)))   next_state = S_SCORE;
      end
      S_SCORE: if (play_clicked) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // One-second prescaler, restarted on every state change and frozen while paused in GAME
  always_ff @(posedge pclk or posedge rst) begin
    if (rst)                                  presc <= '0;
    else if (state_change)                    presc <= '0;
    else if ((cur_state == S_GAME) && paused) presc <= presc;
    else if (tick)                            presc <= '0;
    else                                      presc <= presc + PRESC_W'(1);
  end

  // Counts elapsed seconds in WAIT for the no-opponent timeout
  always_ff @(posedge pclk or posedge rst) begin
    if (rst)                                 tmo_cnt <= '0;
    else if (state_change)                   tmo_cnt <= '0;
    else if ((cur_state == S_WAIT) && tick)  tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  // Remembers an opponent start so it is not lost if it arrives before the local click
  always_ff @(posedge pclk or posedge rst) begin
    if (rst)                                         remote_seen <= 1'b0;
    else if (enter_game || score_to_idle)            remote_seen <= 1'b0;
    else if (remote_start && (cur_state != S_GAME))  remote_seen <= 1'b1;
  end

  // Opponent score is accepted once per round; winner is resolved at the capture edge
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      op_captured <= 1'b0;
      winner      <= 2'd0;
    end else if (enter_game) begin
      op_captured <= 1'b0;
      winner      <= 2'd0;
    end else if ((cur_state == S_SCORE) && op_score_valid && !op_captured) begin
      op_captured <= 1'b1;
      if (my_score > op_score)      winner <= 2'd1;
      else if (my_score < op_score) winner <= 2'd2;
      else                          winner <= 2'd3;
    end
  end

  // Local score and round timer; a hit on the final edge of the round still counts
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      my_score  <= '0;
      time_left <= '0;
    end else if (enter_game) begin
      my_score  <= '0;
      time_left <= ROUND_T;
    end else begin
      if (hit_ok && (my_score != SCORE_MAX)) my_score <= my_score + SCORE_W'(1);
      if (game_run && tick && !stop_req)     time_left <= time_left - TIME_W'(1);
    end
  end

  // Single-cycle pulses toward the UART and the target generator
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      start_req  <= 1'b0;
      new_target <= 1'b0;
    end else begin
      start_req  <= (cur_state == S_IDLE) && (next_state == S_WAIT);
      new_target <= enter_game || hit_ok;
    end
  end

endmodule

// File: doc/game_flow_ctl.md
Name: game_flow_ctl

Overview:
Parametrised game-flow controller. It sequences IDLE → WAIT → GAME → SCORE for the two-player duck game, runs the round timer and owns the local score. It captures the opponent score from the UART side and produces the winner code. It sits on pclk between the click/mouse logic, the UART link and the per-state renderers, and drives the 2-bit state bus used by the background and rgb mux.

Parameters:
CLK_HZ, 75000000, pclk frequency; the prescaler divides by this to get a 1 s tick
ROUND_S, 30, round length in seconds (1..2^TIME_W-1)
WAIT_TIMEOUT_S, 60, seconds in WAIT without remote start before returning to IDLE
SCORE_W, 8, width of local/opponent score
TIME_W, 7, width of time_left

Ports:
pclk  in  1  pixel clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
play_clicked  in  1  1-cycle pulse, play rectangle clicked
remote_start  in  1  1-cycle pulse from UART, opponent ready
stop_req  in  1  1-cycle pulse, mouse right button
duck_hit  in  1  1-cycle pulse, target hit
op_score  in  SCORE_W  opponent score from UART
op_score_valid  in  1  1-cycle strobe, op_score is valid
pause  in  1  freeze request (present only with GAME_PAUSE_EN)
state  out  2  00 IDLE, 01 WAIT, 10 GAME, 11 SCORE
start_req  out  1  1-cycle pulse to UART, local player ready
new_target  out  1  1-cycle pulse, request new random target position
my_score  out  SCORE_W  local score
time_left  out  TIME_W  seconds remaining in round
winner  out  2  0 pending, 1 local, 2 opponent, 3 tie

Behaviour:
- Reset (async, any time, including mid-round): state=IDLE; start_req=0, new_target=0, my_score=0, time_left=0, winner=0; prescaler, timeout counter, remote-seen flag and op-score-captured flag all cleared.
- Outputs are registered. A state change is visible on state one cycle after the causing input.
- remote-seen flag: set by remote_start in any state except GAME. Cleared on entry to GAME and on entry to IDLE from SCORE. A remote_start arriving before the local click is therefore not lost.
- Prescaler counts 0..CLK_HZ-1. tick=1 at count CLK_HZ-1. The prescaler is zeroed on every state entry.
- IDLE: play_clicked → WAIT. start_req pulses in the same cycle state becomes WAIT.
- WAIT:
  - remote-seen set (including a remote_start in this cycle) → GAME.
  - stop_req → IDLE.
  - WAIT_TIMEOUT_S ticks elapsed → IDLE.
  - Priority: remote > stop > timeout.
- Entry to GAME: my_score=0, time_left=ROUND_S, winner=0, op-captured cleared, new_target pulses once.
- GAME:
  - Each tick decrements time_left.
  - Tick with time_left==1 → SCORE with time_left=0.
  - stop_req → SCORE immediately; time_left holds its value.
  - duck_hit → my_score+1, saturating at 2^SCORE_W-1. new_target pulses the following cycle.
  - duck_hit in the same cycle as expiry or stop is still counted.
- SCORE:
  - The first op_score_valid latches op_score. Later strobes are ignored until the next GAME.
  - One cycle after capture, winner = 1 if my_score>op_score, 2 if less, 3 if equal. winner stays 0 until capture.
  - play_clicked → IDLE; winner and my_score hold for display.
  - A duck_hit in SCORE is ignored.
- op_score_valid in a state other than SCORE is ignored. duck_hit outside GAME is ignored.

Optional Feature:
GAME_PAUSE_EN:
- Defined:
  - The pause port exists. While pause=1 in GAME, the prescaler and time_left freeze and duck_hit is ignored.
  - stop_req is still honoured.
  - state stays 10. On release, counting resumes from the frozen prescaler value.
- Undefined: there is no pause port and the round always runs.

Test Plan:
- CLK_HZ=10, ROUND_S=3. play_clicked, then remote_start 5 cycles later → start_req pulse on WAIT entry; GAME entered with time_left=3; SCORE reached after exactly 30 cycles with time_left=0.
- remote_start in IDLE, play_clicked 20 cycles later → WAIT for one cycle, then GAME; new_target pulses once on entry.
- In GAME, 5 duck_hit pulses, the last coincident with the expiry tick → SCORE with my_score=5. SCORE_W=2 with 5 hits → my_score saturates at 3.
- In SCORE with my_score=4: op_score=4 strobed → winner=3 one cycle later. A second strobe with 9 → winner stays 3. play_clicked → IDLE with my_score=4 held.
- WAIT with no remote for WAIT_TIMEOUT_S ticks → IDLE. stop_req in GAME with time_left=2 → SCORE with time_left=2. rst asserted mid-GAME → state=00, all outputs 0 without waiting for a clock.
- With GAME_PAUSE_EN defined, pause high for 25 cycles in GAME → time_left unchanged and hits ignored; after release the round ends 25 cycles later than it would without the pause.
